regfile_2r1w_dump: RTL and testbench
====================================

Name: regfile_2r1w_dump

Overview:
- General-purpose register file for the MIPS core: the read-side counterpart of the team's single-word enabled register.
- Holds 2**ADDR_W words. Two asynchronous read ports (rs/rt) feed decode; one synchronous write port is driven from writeback.
- Includes a sequential dump engine. It walks every register in order over a valid/ready stream so the VGA debug overlay can display CPU state.

Parameters:
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- DATA_W, 32, register word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read port A address (rs).
- rdata_a  out  DATA_W  read port A data.
- raddr_b  in  ADDR_W  read port B address (rt).
- rdata_b  out  DATA_W  read port B data.
- dump_req  in  1  start-dump request; level sampled while the engine is idle.
- dump_busy  out  1  high in RUN and DONE states.
- dump_valid  out  1  dump_idx/dump_data hold a valid beat.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  ADDR_W  index of the register being presented.
- dump_data  out  DATA_W  contents of register dump_idx.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: the interface is one clock (clk) with asynchronous, active-low reset (rst_n).
  - rst_n low immediately clears all registers to 0, FSM to IDLE, dump_idx to 0, and dump_valid/dump_busy/dump_done to 0.
  - Reset takes effect regardless of clk and regardless of any dump in progress.
- Write: on rising clk, if we=1 and waddr!=0, reg[waddr] <= wdata.
  - Writes to address 0 are discarded; reg[0] always reads 0.
- Read: rdata_a/rdata_b are combinational: reg[raddr] with zero latency. Address 0 returns 0.
  - Simultaneous write and read of the same address returns the OLD value, unless REGFILE_BYPASS_EN is defined (see Optional Feature).
- Dump FSM, states IDLE, RUN, DONE:
  - IDLE: dump_valid=0. If dump_req=1 at a clk edge, go to RUN with dump_idx<=0.
  - RUN: dump_valid=1. dump_data = reg[dump_idx], combinational, never bypassed; reflects the committed contents this cycle.
    - A beat transfers when dump_valid&&dump_ready at a clk edge.
    - On transfer with dump_idx != 2**ADDR_W-1: dump_idx<=dump_idx+1.
    - On transfer with dump_idx == 2**ADDR_W-1: go to DONE; dump_idx holds its value.
    - With dump_ready=0, dump_idx/dump_data stay stable; dump_data may change only if that register is written.
  - DONE: dump_done=1 and dump_valid=0 for exactly one cycle, then IDLE with dump_idx<=0.
  - dump_req is ignored outside IDLE. If dump_req is held high continuously, a new dump starts on the cycle after returning to IDLE.
  - Register writes proceed normally during a dump. Registers already emitted are not re-sent.
- Width rules: index increment is ADDR_W bits; the wrap from max index never occurs because the FSM exits to DONE.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1 and waddr!=0 and waddr==raddr_x, then rdata_x=wdata in the same cycle, on each read port independently. Address 0 still returns 0.
- Undefined: no forwarding; reads return stored contents only. Writeback/decode hazards are resolved by the pipeline's half-cycle write convention.
- The dump path is unaffected either way.

Test Plan:
- Reset: write reg[5]=32'hDEADBEEF, pulse rst_n low mid-cycle -> rdata for address 5 is 0 immediately; dump_busy=0 and dump_valid=0.
- Write then read: we=1, waddr=7, wdata=32'h12345678; next cycle raddr_a=7, raddr_b=0 -> rdata_a=32'h12345678, rdata_b=0.
  - Then we=1, waddr=0, wdata=32'hFFFFFFFF -> address 0 still reads 0.
- Same-cycle hazard: we=1, waddr=3, wdata=32'hA5A5A5A5, raddr_a=3, reg[3] previously 1:
  - Without macro: rdata_a=1.
  - With REGFILE_BYPASS_EN: rdata_a=32'hA5A5A5A5.
- Full dump: preload reg[i]=i*4, pulse dump_req, hold dump_ready=1 -> 32 consecutive beats with idx 0..31 and data 0,4,...,124; then dump_done high for one cycle, then IDLE.
- Backpressure: during a dump, drop dump_ready for 3 cycles at idx 10 -> idx stays 10 with data stable; resumes at 11 when ready returns; total accepted beats = 32.
- Reset mid-dump: assert rst_n low at idx 17 -> dump_valid=0 and dump_idx=0 at once; after release, a new dump_req restarts at idx 0.

Source files
------------

// File: rtl/regfile_2r1w_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_2r1w_dump                                               |
// | Desc   : 2-read/1-write register file (reg 0 hard-wired to zero) with a  |
// |          valid/ready dump engine that streams every register in order.   |
// |          Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read      |
// |          forwarding on both read ports (dump path never forwarded).      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module regfile_2r1w_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int                c_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_stored_a;
  logic [DATA_W-1:0] w_stored_b;

  assign w_wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign w_stored_a = (raddr_a == '0) ? '0 : r_mem[raddr_a];
  assign w_stored_b = (raddr_b == '0) ? '0 : r_mem[raddr_b];

`ifdef REGFILE_BYPASS_EN
  // Forwarding is qualified by w_wr_en, so address 0 can never forward.
  assign rdata_a = (w_wr_en && (waddr == raddr_a)) ? wdata : w_stored_a;
  assign rdata_b = (w_wr_en && (waddr == raddr_b)) ? wdata : w_stored_b;
`else
  assign rdata_a = w_stored_a;
  assign rdata_b = w_stored_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (dump_ready) begin
            if (r_idx == c_LAST) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_busy  = r_busy;
  assign dump_valid = r_valid;
  assign dump_done  = r_done;
  assign dump_idx   = r_idx;
  assign dump_data  = r_mem[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_dump.sv
`default_nettype none
// Testbench for regfile_2r1w_dump: directed scenarios plus randomized traffic
// checked against an array model of the register file and dump order.
module tb_regfile_2r1w_dump;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [DW-1:0] rdata_a;
  logic [AW-1:0] raddr_b = '0;
  logic [DW-1:0] rdata_b;
  logic          dump_req = 1'b0;
  logic          dump_busy;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;
  logic          dump_done;

  logic [DW-1:0] model [N];
  int checks = 0;
  int errors = 0;

  regfile_2r1w_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Advance one rising edge, commit the write the model expects, settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && waddr != 0) model[waddr] = wdata;
    #1;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  task automatic test_reset();
    clear_model();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr_a = 5'd5;
    #1;
    checks++;
    if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_prewrite got %h want %h", rdata_a, 32'hDEADBEEF); end
    #1;
    rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (rdata_a !== '0) begin errors++; $display("FAIL reset_clear got %h want 0", rdata_a); end
    checks++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== '0)
      begin errors++; $display("FAIL reset_dump busy=%b valid=%b done=%b idx=%0d want 0 0 0 0", dump_busy, dump_valid, dump_done, dump_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    tick();
    we = 1'b0; raddr_a = 5'd7; raddr_b = 5'd0;
    #1;
    checks++;
    if (rdata_a !== 32'h12345678) begin errors++; $display("FAIL wr_rd_a got %h want %h", rdata_a, 32'h12345678); end
    checks++;
    if (rdata_b !== '0) begin errors++; $display("FAIL wr_rd_b0 got %h want 0", rdata_b); end
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
    #1;
    checks++;
    if (rdata_a !== '0) begin errors++; $display("FAIL wr0_same_cycle got %h want 0", rdata_a); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata_a !== '0 || rdata_b !== '0) begin errors++; $display("FAIL wr0_after a=%h b=%h want 0", rdata_a, rdata_b); end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] want;
    we = 1'b1; waddr = 5'd3; wdata = 32'd1;
    tick();
    wdata = 32'hA5A5A5A5; raddr_a = 5'd3; raddr_b = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'd1;
`endif
    checks++;
    if (rdata_a !== want) begin errors++; $display("FAIL hazard_a got %h want %h", rdata_a, want); end
    checks++;
    if (rdata_b !== 32'h12345678) begin errors++; $display("FAIL hazard_b got %h want %h", rdata_b, 32'h12345678); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata_a !== 32'hA5A5A5A5) begin errors++; $display("FAIL hazard_commit got %h want %h", rdata_a, 32'hA5A5A5A5); end
  endtask

  task automatic test_full_dump();
    int beats = 0;
    int cyc = 0;
    for (int i = 1; i < N; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = DW'(i * 4);
      tick();
    end
    we = 1'b0;
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (beats < N && cyc < 200) begin
      if (dump_valid && dump_ready) begin
        checks++;
        if (dump_idx !== AW'(beats)) begin errors++; $display("FAIL full_idx got %0d want %0d", dump_idx, beats); end
        checks++;
        if (dump_data !== DW'(beats * 4)) begin errors++; $display("FAIL full_data idx=%0d got %h want %h", beats, dump_data, beats * 4); end
        beats++;
      end
      tick(); cyc++;
    end
    checks++;
    if (beats != N || cyc != N) begin errors++; $display("FAIL full_count beats=%0d cycles=%0d want %0d", beats, cyc, N); end
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1)
      begin errors++; $display("FAIL full_done done=%b valid=%b busy=%b want 1 0 1", dump_done, dump_valid, dump_busy); end
    tick();
    checks++;
    if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== '0)
      begin errors++; $display("FAIL full_idle done=%b busy=%b valid=%b idx=%0d want 0 0 0 0", dump_done, dump_busy, dump_valid, dump_idx); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [DW-1:0] held;
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (beats < N && cyc < 200) begin
      if (dump_valid && dump_idx == 5'd10 && !stalled) begin
        stalled = 1;
        dump_ready = 1'b0;
        held = dump_data;
        repeat (3) begin
          tick();
          checks++;
          if (dump_idx !== 5'd10 || dump_valid !== 1'b1 || dump_data !== held)
            begin errors++; $display("FAIL bp_stall idx=%0d valid=%b data=%h want 10 1 %h", dump_idx, dump_valid, dump_data, held); end
        end
        dump_ready = 1'b1;
      end
      if (dump_valid && dump_ready) begin
        checks++;
        if (dump_idx !== AW'(beats) || dump_data !== model[beats])
          begin errors++; $display("FAIL bp_beat idx=%0d data=%h want %0d %h", dump_idx, dump_data, beats, model[beats]); end
        beats++;
      end
      tick(); cyc++;
    end
    checks++;
    if (beats != N || !stalled) begin errors++; $display("FAIL bp_count beats=%0d stalled=%0d want %0d 1", beats, stalled, N); end
    checks++;
    if (dump_done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", dump_done); end
    tick();
  endtask

  task automatic test_random();
    int beats = 0;
    int dumps = 0;
    int cyc = 0;
    int done_at = -10;
    dump_req = 1'b1;
    while (dumps < 3 && cyc < 2000) begin
      we = 1'($urandom_range(0, 1));
      waddr = AW'($urandom);
      wdata = $urandom;
      raddr_a = AW'($urandom);
      raddr_b = ($urandom_range(0, 3) != 0) ? AW'($urandom) : waddr;
      dump_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (rdata_a !== exp_read(raddr_a)) begin errors++; $display("FAIL rnd_rd_a addr=%0d got %h want %h", raddr_a, rdata_a, exp_read(raddr_a)); end
      checks++;
      if (rdata_b !== exp_read(raddr_b)) begin errors++; $display("FAIL rnd_rd_b addr=%0d got %h want %h", raddr_b, rdata_b, exp_read(raddr_b)); end
      if (dump_valid) begin
        checks++;
        if (dump_idx !== AW'(beats)) begin errors++; $display("FAIL rnd_idx got %0d want %0d", dump_idx, beats); end
        checks++;
        if (dump_data !== model[dump_idx]) begin errors++; $display("FAIL rnd_data idx=%0d got %h want %h", dump_idx, dump_data, model[dump_idx]); end
      end
      if (cyc == done_at + 1) begin
        checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle busy=%b valid=%b want 0 0", dump_busy, dump_valid); end
      end
      if (cyc == done_at + 2) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== '0) begin errors++; $display("FAIL rnd_restart valid=%b idx=%0d want 1 0", dump_valid, dump_idx); end
      end
      if (dump_done) begin
        checks++;
        if (beats != N) begin errors++; $display("FAIL rnd_done_beats got %0d want %0d", beats, N); end
        dumps++; beats = 0; done_at = cyc;
      end
      if (dump_valid && dump_ready) beats++;
      tick(); cyc++;
    end
    dump_req = 1'b0; we = 1'b0;
    checks++;
    if (dumps != 3) begin errors++; $display("FAIL rnd_dumps got %0d want 3", dumps); end
  endtask

  task automatic test_reset_mid_dump();
    int cyc = 0;
    dump_ready = 1'b1;
    while (dump_busy && cyc < 100) begin tick(); cyc++; end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (dump_idx != 5'd17 && cyc < 200) begin tick(); cyc++; end
    checks++;
    if (dump_idx !== 5'd17 || dump_valid !== 1'b1) begin errors++; $display("FAIL mid_reach idx=%0d valid=%b want 17 1", dump_idx, dump_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (dump_valid !== 1'b0 || dump_idx !== '0 || dump_busy !== 1'b0)
      begin errors++; $display("FAIL mid_reset valid=%b idx=%0d busy=%b want 0 0 0", dump_valid, dump_idx, dump_busy); end
    #1;
    rst_n = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== '0 || dump_data !== '0)
      begin errors++; $display("FAIL mid_restart valid=%b idx=%0d data=%h want 1 0 0", dump_valid, dump_idx, dump_data); end
    tick();
    checks++;
    if (dump_idx !== 5'd1) begin errors++; $display("FAIL mid_advance idx=%0d want 1", dump_idx); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_full_dump();
    test_backpressure();
    test_random();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
